mem_sp_arbiter: RTL and testbench

MEM_SP_ARBITER -- requirements
Module: mem_sp_arbiter

---
 rtl/mem_sp_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_sp_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sp_arbiter.sv
// Round-robin arbiter that shares one single-port memory among NUM_REQ requesters,
// with optional zero-fill after reset and in-order read responses after READ_LAT cycles.
module mem_sp_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_BIT = 64,
    parameter int DEPTH    = 256,
    parameter int ADDR_BIT = $clog2(DEPTH),
    parameter int READ_LAT = 2,
    parameter int INIT_EN  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_BIT-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_BIT-1:0]          rsp_rdata,
    output logic [ADDR_BIT-1:0]          mem_addr,
    output logic                         mem_wen,
    output logic                         mem_ren,
    output logic [DATA_BIT-1:0]          mem_wdata,
    input  logic [DATA_BIT-1:0]          mem_rdata,
    output logic                         init_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_BIT-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [READ_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [IDX_W-1:0]    tag_idx_q [READ_LAT];
    logic [IDX_W-1:0]    tag_idx_d [READ_LAT];

    logic                grant_vld;
    logic [IDX_W-1:0]    grant_idx;
    logic                read_fire;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state_q == ST_RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_vld && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                    grant_vld = 1'b1;
                    grant_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
                end
            end
        end
    end

    assign read_fire = grant_vld && !req_we[grant_idx];

    always_comb begin
        req_ready = '0;
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        mem_wdata = '0;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_wen  = 1'b1;
                mem_addr = cnt_q;
            end else if (grant_vld) begin
                req_ready[grant_idx] = 1'b1;
                mem_addr  = req_addr[int'(grant_idx)*ADDR_BIT +: ADDR_BIT];
                mem_wdata = req_wdata[int'(grant_idx)*DATA_BIT +: DATA_BIT];
                mem_wen   = req_we[grant_idx];
                mem_ren   = !req_we[grant_idx];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_BIT'(1);
            if (cnt_q == ADDR_BIT'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end else if (grant_vld) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Tag pipeline: stage 0 captures the read grant, later stages shift it along.
    always_comb begin
        tag_vld_d[0] = read_fire;
        tag_idx_d[0] = grant_idx;
        for (int s = 1; s < READ_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            cnt_q     <= '0;
            ptr_q     <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s < READ_LAT; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            tag_vld_q <= tag_vld_d;
            for (int s = 0; s < READ_LAT; s++) begin
                tag_idx_q[s] <= tag_idx_d[s];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = !rst && tag_vld_q[READ_LAT-1]
                                   && (tag_idx_q[READ_LAT-1] == IDX_W'(gi));
        end
    endgenerate

    assign rsp_rdata = (|rsp_valid) ? mem_rdata : '0;
    assign init_done = !rst && (state_q == ST_RUN);

endmodule

// File: tb/tb_mem_sp_arbiter.sv
// Directed bench for mem_sp_arbiter: stimulus pushes expected read responses,
// a monitor pops them whenever rsp_valid is seen. Includes a READ_LAT=2 memory model.
module tb_mem_sp_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_we;
    logic [15:0]  req_addr;
    logic [127:0] req_wdata;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_rdata;
    logic [7:0]   mem_addr;
    logic         mem_wen;
    logic         mem_ren;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;
    logic         init_done;

    mem_sp_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    // Single-port memory with two-cycle read latency, pre-filled with non-zero junk.
    logic [63:0] mem_arr [0:255];
    logic [63:0] rd_pipe [0:1];
    assign mem_rdata = rd_pipe[1];

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        rd_pipe[0] = '0;
        rd_pipe[1] = '0;
    end

    always @(posedge clk) begin
        if (mem_wen) mem_arr[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem_ren ? mem_arr[mem_addr] : 64'h0BAD_0BAD_0BAD_0BAD;
        rd_pipe[1] <= rd_pipe[0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
    localparam logic [63:0] DC = 64'hDEAD_BEEF_0000_0001;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // One request cycle: inputs at negedge, combinational outputs checked 1ns later.
    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [1:0] exp_rdy, input logic push,
                         input logic [63:0] exp_rd);
        int idx;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            idx = exp_rdy[1] ? 1 : 0;
            chk("mem_addr", 64'(mem_addr), 64'(idx == 1 ? a1 : a0));
            chk("mem_wen", 64'(mem_wen), 64'(we[idx]));
            chk("mem_ren", 64'(mem_ren), 64'(!we[idx]));
            if (we[idx]) chk("mem_wdata", mem_wdata, idx == 1 ? d1 : d0);
            else if (push) q.push_back('{idx, exp_rd, cyc + 2});
        end else begin
            chk("mem_idle", 64'({mem_wen, mem_ren}), 64'(0));
        end
        $display("REQ cyc=%0d valid=%b we=%b ready=%b", cyc, v, we, req_ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 8'd0, 8'd0, '0, '0, 2'b00, 1'b0, '0);
    endtask

    // Full zero-fill sequence, starting in the cycle where rst is released.
    task automatic init_check();
        logic ok;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            ok = mem_wen && !mem_ren && (mem_addr == 8'(i)) && (mem_wdata == 64'd0)
                 && (req_ready == 2'b00) && !init_done;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL init_step %0d got wen=%b ren=%b addr=%0d wdata=%h ready=%b done=%b required wen=1 addr=%0d wdata=0 ready=0 done=0",
                         i, mem_wen, mem_ren, mem_addr, mem_wdata, req_ready, init_done, i);
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("init_done_after_fill", 64'(init_done), 64'd1);
        chk("run_mem_wen_idle", 64'(mem_wen), 64'd0);
    endtask

    // Response monitor / scoreboard.
    exp_t e;
    int   act_idx;
    always @(negedge clk) begin
        #2;
        if (rsp_valid != 2'b00) begin
            act_idx = (rsp_valid == 2'b01) ? 0 : (rsp_valid == 2'b10) ? 1 : -1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected cyc=%0d got valid=%b data=%h required none", cyc, rsp_valid, rsp_rdata);
            end else begin
                e = q.pop_front();
                if (act_idx != e.idx || rsp_rdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rsp got req=%0d data=%h cyc=%0d required req=%0d data=%h cyc=%0d",
                             act_idx, rsp_rdata, cyc, e.idx, e.data, e.cyc);
                end else begin
                    $display("RSP cyc=%0d req=%0d data=%h", cyc, act_idx, rsp_rdata);
                end
            end
        end else begin
            checks++;
            if (rsp_rdata !== 64'd0) begin
                errors++;
                $display("FAIL rsp_rdata_idle cyc=%0d got %h required 0", cyc, rsp_rdata);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({req_ready, rsp_valid, mem_wen, mem_ren, init_done}), 64'd0);
        chk("reset_addr_data", 64'(mem_addr) | mem_wdata | rsp_rdata, 64'd0);

        @(negedge clk);
        rst = 1'b0;
        init_check();

        // Pre-load addr 10/11, then both requesters read continuously.
        drive(2'b01, 2'b01, 8'd10, 8'd0, DA, '0, 2'b01, 1'b0, '0);
        drive(2'b10, 2'b10, 8'd0, 8'd11, '0, DB, 2'b10, 1'b0, '0);
        drive(2'b11, 2'b00, 8'd10, 8'd11, '0, '0, 2'b01, 1'b1, DA);
        drive(2'b11, 2'b00, 8'd10, 8'd11, '0, '0, 2'b10, 1'b1, DB);
        drive(2'b11, 2'b00, 8'd10, 8'd11, '0, '0, 2'b01, 1'b1, DA);
        drive(2'b11, 2'b00, 8'd10, 8'd11, '0, '0, 2'b10, 1'b1, DB);

        // Write then read the same address on consecutive cycles.
        drive(2'b01, 2'b01, 8'd5, 8'd0, DC, '0, 2'b01, 1'b0, '0);
        drive(2'b01, 2'b00, 8'd5, 8'd0, '0, '0, 2'b01, 1'b1, DC);

        // Untouched address after zero-fill.
        drive(2'b10, 2'b00, 8'd0, 8'd200, '0, '0, 2'b10, 1'b1, 64'd0);

        // Lone requester 1 is granted every cycle.
        for (int i = 0; i < 10; i++) drive(2'b10, 2'b00, 8'd0, 8'd11, '0, '0, 2'b10, 1'b1, DB);

        idle(4);
        chk("queue_drained", 64'(q.size()), 64'd0);

        // Two reads in flight, then reset: both responses must be dropped.
        drive(2'b11, 2'b00, 8'd10, 8'd11, '0, '0, 2'b01, 1'b0, '0);
        drive(2'b11, 2'b00, 8'd10, 8'd11, '0, '0, 2'b10, 1'b0, '0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("midreset_outputs", 64'({req_ready, rsp_valid, mem_wen, mem_ren, init_done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b11;
        init_check();

        // Zero-fill after the second reset overwrote addr 10; pointer is back at 0.
        drive(2'b11, 2'b00, 8'd10, 8'd11, '0, '0, 2'b01, 1'b1, 64'd0);
        idle(4);
        chk("queue_drained_final", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
